// File: rtl/pipe_perf_monitor_if.sv
// Control, status and counter-readback signals of the pipeline performance monitor.
// The master drives stimulus and read select; the slave is the monitor itself.
interface pipe_perf_monitor_if #(
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned NUM_EVT = 4
);
    localparam int unsigned SEL_W = (NUM_EVT > 1) ? $clog2(NUM_EVT) : 1;

    logic               start;
    logic               clear;
    logic [31:0]        instr_if;
    logic [NUM_EVT-1:0] evt;
    logic [SEL_W-1:0]   rd_sel;
    logic [CNT_W-1:0]   cycle_count;
    logic [CNT_W-1:0]   evt_count;
    logic               busy;
    logic               halted;
    logic               timeout;
    logic               done;

    modport master (
        output start, clear, instr_if, evt, rd_sel,
        input  cycle_count, evt_count, busy, halted, timeout, done
    );

    modport slave (
        input  start, clear, instr_if, evt, rd_sel,
        output cycle_count, evt_count, busy, halted, timeout, done
    );
endinterface

// File: rtl/pipe_perf_monitor.sv
// Pipeline performance monitor: counts run cycles and event strobes from start until
// a halt instruction (plus drain window) or a cycle limit, then freezes for readback.
module pipe_perf_monitor #(
    parameter int unsigned CNT_W        = 32,
    parameter int unsigned NUM_EVT      = 4,
    parameter logic [31:0] HALT_INSTR   = 32'h0000_0000,
    parameter int unsigned MAX_CYCLES   = 1000,
    parameter int unsigned DRAIN_CYCLES = 4
) (
    input logic               clk,
    input logic               reset_n,
    pipe_perf_monitor_if.slave bus
);
    localparam int unsigned DW         = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam int unsigned DRAIN_LOAD = (DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0;
    // Wide enough that MAX_CYCLES is never truncated against a narrow counter.
    localparam int unsigned CW         = (CNT_W > 32) ? CNT_W : 32;

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e                          state_q, state_d;
    logic [DW-1:0]                   drain_q, drain_d;
    logic                            halted_q, halted_d;
    logic                            timeout_q, timeout_d;
    logic                            done_q, done_d;
    logic [CNT_W-1:0]                cycle_q, cycle_d;
    logic [NUM_EVT-1:0][CNT_W-1:0]   evt_q, evt_d;
    logic                            cnt_en;
    logic                            limit_hit;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    assign limit_hit = (CW'(cycle_q) == CW'(MAX_CYCLES - 1));

    always_comb begin
        state_d   = state_q;
        drain_d   = drain_q;
        halted_d  = halted_q;
        timeout_d = timeout_q;
        unique case (state_q)
            StIdle: if (bus.start) state_d = StRun;
            StRun: begin
                // A halt on the limit cycle takes priority over the timeout.
                if (bus.instr_if == HALT_INSTR) begin
                    halted_d = 1'b1;
                    if (DRAIN_CYCLES == 0) begin
                        state_d = StDone;
                    end else begin
                        state_d = StDrain;
                        drain_d = DW'(DRAIN_LOAD);
                    end
                end else if (limit_hit) begin
                    state_d   = StDone;
                    timeout_d = 1'b1;
                end
            end
            StDrain: begin
                if (drain_q == '0) state_d = StDone;
                else               drain_d = drain_q - DW'(1);
            end
            StDone: state_d = StDone;
            default: state_d = StIdle;
        endcase
        if (bus.clear) begin
            state_d   = StIdle;
            drain_d   = '0;
            halted_d  = 1'b0;
            timeout_d = 1'b0;
        end
        done_d = (state_d == StDone) && (state_q != StDone);
    end

    assign cnt_en = (state_q == StRun) || (state_q == StDrain);

    always_comb begin
        cycle_d = cycle_q;
        evt_d   = evt_q;
        if (bus.clear) begin
            cycle_d = '0;
            evt_d   = '0;
        end else if (cnt_en) begin
            cycle_d = sat_inc(cycle_q);
            for (int k = 0; k < NUM_EVT; k++) begin
                if (bus.evt[k]) evt_d[k] = sat_inc(evt_q[k]);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            drain_q   <= '0;
            halted_q  <= 1'b0;
            timeout_q <= 1'b0;
            done_q    <= 1'b0;
            cycle_q   <= '0;
            evt_q     <= '0;
        end else begin
            state_q   <= state_d;
            drain_q   <= drain_d;
            halted_q  <= halted_d;
            timeout_q <= timeout_d;
            done_q    <= done_d;
            cycle_q   <= cycle_d;
            evt_q     <= evt_d;
        end
    end

    always_comb begin
        bus.evt_count = '0;
        if (32'(bus.rd_sel) < NUM_EVT) bus.evt_count = evt_q[bus.rd_sel];
    end

    assign bus.cycle_count = cycle_q;
    assign bus.busy        = cnt_en;
    assign bus.halted      = halted_q;
    assign bus.timeout     = timeout_q;
    assign bus.done        = done_q;
endmodule

// File: tb/tb_pipe_perf_monitor.sv
// Randomized scoreboard bench for pipe_perf_monitor: each run's expected result comes from
// a per-cycle trace model and is checked when the DUT pulses done; a narrow instance covers saturation.
module tb_pipe_perf_monitor;
    localparam int unsigned CNT_W     = 32;
    localparam int unsigned NUM_EVT   = 4;
    localparam int unsigned MAX_CYC   = 1000;
    localparam int unsigned DRAIN     = 4;
    localparam logic [31:0] HALT      = 32'h0000_0000;
    localparam int unsigned S_CNT_W   = 4;
    localparam int unsigned S_NUM_EVT = 3;
    localparam int unsigned S_MAX     = 100;

    typedef struct packed {
        logic [CNT_W-1:0]              cyc;
        logic                          halted;
        logic                          timeout;
        logic [NUM_EVT-1:0][CNT_W-1:0] ev;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    pipe_perf_monitor_if #(.CNT_W(CNT_W), .NUM_EVT(NUM_EVT)) m ();
    pipe_perf_monitor_if #(.CNT_W(S_CNT_W), .NUM_EVT(S_NUM_EVT)) s ();

    pipe_perf_monitor #(
        .CNT_W(CNT_W), .NUM_EVT(NUM_EVT), .HALT_INSTR(HALT),
        .MAX_CYCLES(MAX_CYC), .DRAIN_CYCLES(DRAIN)
    ) u_dut (
        .clk(clk), .reset_n(reset_n), .bus(m)
    );

    pipe_perf_monitor #(
        .CNT_W(S_CNT_W), .NUM_EVT(S_NUM_EVT), .HALT_INSTR(HALT),
        .MAX_CYCLES(S_MAX), .DRAIN_CYCLES(0)
    ) u_dut_small (
        .clk(clk), .reset_n(reset_n), .bus(s)
    );

    exp_t exp_q[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   pushed     = 0;
    int   checked    = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] sat(input longint unsigned x, input int w);
        longint unsigned maxv;
        maxv = (64'd1 << w) - 64'd1;
        return (x > maxv) ? maxv : x;
    endfunction

    // A run lasts up to the halt cycle (then DRAIN more) or MAX_CYC cycles; events count in that span.
    function automatic exp_t model(input int h, input logic [NUM_EVT-1:0] ev_arr[$]);
        exp_t e;
        int   run_len, total;
        longint unsigned cnt;
        e.halted  = (h >= 0) && (h < int'(MAX_CYC));
        e.timeout = !e.halted;
        run_len   = e.halted ? h + 1 : int'(MAX_CYC);
        total     = run_len + (e.halted ? int'(DRAIN) : 0);
        e.cyc     = CNT_W'(sat(longint'(total), CNT_W));
        for (int k = 0; k < NUM_EVT; k++) begin
            cnt = 0;
            for (int i = 0; i < total; i++) cnt += ev_arr[i][k];
            e.ev[k] = CNT_W'(sat(cnt, CNT_W));
        end
        return e;
    endfunction

    // h < 0 means never halt; mode 1 uses the directed evt0x3 / evt2x5 pattern.
    task automatic do_run(input int h, input int mode);
        logic [31:0]        ins[$];
        logic [NUM_EVT-1:0] ev[$];
        logic [NUM_EVT-1:0] ev_v;
        int                 n, b;
        n = ((h >= 0 && h < int'(MAX_CYC)) ? h + 1 + int'(DRAIN) : int'(MAX_CYC)) + 3;
        for (int i = 0; i < n; i++) begin
            if (i == h) ins.push_back(HALT);
            else if ((h >= 0 && i > h) || i >= int'(MAX_CYC)) ins.push_back($urandom);
            else ins.push_back($urandom | 32'h1);
            if (mode == 1) begin
                ev_v = '0;
                if (i < 3) ev_v[0] = 1'b1;
                if (i >= 4 && i < 9) ev_v[2] = 1'b1;
            end else begin
                ev_v = NUM_EVT'($urandom);
            end
            ev.push_back(ev_v);
        end
        exp_q.push_back(model(h, ev));
        pushed++;
        m.start = 1'b1; m.evt = NUM_EVT'($urandom); m.instr_if = $urandom;
        step();
        m.start = 1'b0;
        for (int i = 0; i < n; i++) begin
            m.instr_if = ins[i];
            m.evt      = ev[i];
            if ((i % 7) == 3) m.start = 1'b1;
            step();
            m.start = 1'b0;
        end
        b = 0;
        while (checked < pushed && b < 50) begin
            step();
            b++;
        end
        if (checked < pushed) begin
            chk("done_wait", 64'(checked), 64'(pushed));
            exp_q.delete();
            checked = pushed;
        end
        m.clear = 1'b1;
        step();
        m.clear = 1'b0;
        chk("clr_busy", m.busy, 0);
        chk("clr_cycle", m.cycle_count, 0);
        chk("clr_halted", m.halted, 0);
        chk("clr_timeout", m.timeout, 0);
        chk("clr_done", m.done, 0);
    endtask

    // Monitor: every done pulse must match the oldest outstanding run.
    initial begin
        exp_t e;
        m.rd_sel = '0;
        forever begin
            @(negedge clk);
            if (reset_n && m.done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_done: got done=1 expected no pending run");
                end else begin
                    e = exp_q.pop_front();
                    chk("cycle_count", m.cycle_count, e.cyc);
                    chk("halted", m.halted, e.halted);
                    chk("timeout", m.timeout, e.timeout);
                    chk("busy_at_done", m.busy, 0);
                    for (int k = 0; k < NUM_EVT; k++) begin
                        m.rd_sel = k[1:0];
                        #1;
                        chk($sformatf("evt_count[%0d]", k), m.evt_count, e.ev[k]);
                    end
                    m.rd_sel = '0;
                    repeat (3) @(negedge clk);
                    chk("frozen_cycle", m.cycle_count, e.cyc);
                    chk("done_width", m.done, 0);
                    checked++;
                end
            end
        end
    end

    initial begin
        m.start = 1'b0; m.clear = 1'b0; m.instr_if = 32'h1; m.evt = '0;
        s.start = 1'b0; s.clear = 1'b0; s.instr_if = 32'h1; s.evt = '0; s.rd_sel = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", m.busy, 0);
        chk("rst_cycle", m.cycle_count, 0);
        chk("rst_done", m.done, 0);
        reset_n = 1'b1;
        step();

        do_run(10, 1);     // ten instructions, halt, four drain cycles
        do_run(-1, 0);     // never halts: timeout at the cycle limit
        do_run(int'(MAX_CYC) - 1, 0); // halt on the limit cycle wins
        for (int r = 0; r < 6; r++) do_run(int'($urandom_range(0, 40)), 0);

        // Asynchronous reset in the middle of a run.
        m.start = 1'b1;
        step();
        m.start = 1'b0;
        for (int i = 0; i < 37; i++) begin
            m.instr_if = $urandom | 32'h1;
            m.evt      = NUM_EVT'($urandom);
            step();
        end
        chk("mid_run_busy", m.busy, 1);
        chk("mid_run_cycle", m.cycle_count, 37);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_busy", m.busy, 0);
        chk("arst_cycle", m.cycle_count, 0);
        chk("arst_evt", m.evt_count, 0);
        chk("arst_halted", m.halted, 0);
        chk("arst_timeout", m.timeout, 0);
        chk("arst_done", m.done, 0);
        step();
        reset_n = 1'b1;
        repeat (5) step();
        chk("post_rst_idle", m.busy, 0);

        // Clear and halt on the same cycle.
        m.start = 1'b1;
        step();
        m.start = 1'b0;
        repeat (5) step();
        m.instr_if = HALT;
        m.clear    = 1'b1;
        step();
        m.clear    = 1'b0;
        m.instr_if = 32'h1;
        chk("clrhalt_busy", m.busy, 0);
        chk("clrhalt_halted", m.halted, 0);
        chk("clrhalt_cycle", m.cycle_count, 0);
        repeat (10) step();
        chk("clrhalt_idle", m.busy, 0);

        // Narrow counters saturate; zero drain goes straight to done.
        s.start = 1'b1;
        step();
        s.start = 1'b0;
        for (int i = 0; i < 41; i++) begin
            s.evt      = (i < 40) ? 3'b010 : 3'b000;
            s.instr_if = (i == 40) ? HALT : ($urandom | 32'h1);
            step();
            if (i == 15) chk("small_cycle_16", s.cycle_count, 15);
        end
        chk("small_done", s.done, 1);
        chk("small_busy", s.busy, 0);
        chk("small_halted", s.halted, 1);
        chk("small_timeout", s.timeout, 0);
        chk("small_cycle_sat", s.cycle_count, 15);
        s.rd_sel = 2'd1;
        #1 chk("small_evt1_sat", s.evt_count, 15);
        s.rd_sel = 2'd0;
        #1 chk("small_evt0", s.evt_count, 0);
        s.rd_sel = 2'd3;
        #1 chk("small_sel_oob", s.evt_count, 0);
        step();
        chk("small_done_pulse", s.done, 0);

        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
